// File: rtl/stage_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : stage_id_reg
// Purpose  : Registered RV32I decode stage. Decodes one IF/ID instruction,
//            selects operands with EXE/MEM forwarding, resolves jumps and
//            branches (one-cycle redirect pulse) and holds the result in an
//            ID/EX register with valid/stall/flush handshake, a load-use
//            interlock and a saturating stall-cycle counter.
// Ports    : clk, rst (async, active high), rdy (global run enable)
//            if_valid_i, pc_i, inst_i          - instruction from IF/ID
//            id_ready_o                        - instruction accepted
//            rs1/rs2_addr_o, rs1/rs2_data_i    - register file read port
//            exe_*_i, mem_*_i                  - forwarding sources
//            ex_stall_i, flush_i               - downstream handshake
//            ex_valid_o .. wreg_o              - ID/EX register contents
//            branch_taken_o, branch_addr_o     - redirect pulse and target
//            stall_cnt_o                       - load-use stall cycle count
// Revision : 1.0 - initial release
// ============================================================================
module stage_id_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             if_valid_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      inst_i,
  output logic             id_ready_o,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic             exe_wreg_i,
  input  logic [4:0]       exe_wd_i,
  input  logic [XLEN-1:0]  exe_wdata_i,
  input  logic             exe_is_load_i,
  input  logic             mem_wreg_i,
  input  logic [4:0]       mem_wd_i,
  input  logic [XLEN-1:0]  mem_wdata_i,
  input  logic             ex_stall_i,
  input  logic             flush_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [6:0]       opcode_o,
  output logic [2:0]       func3_o,
  output logic [6:0]       func7_o,
  output logic [XLEN-1:0]  data1_o,
  output logic [XLEN-1:0]  data2_o,
  output logic [XLEN-1:0]  ls_offset_o,
  output logic [4:0]       wd_o,
  output logic             wreg_o,
  output logic             branch_taken_o,
  output logic [XLEN-1:0]  branch_addr_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_op     = 7'b0110011;

  // Sign-extend a 32-bit immediate to the datapath width.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Operand source priority: x0, then EXE result, then MEM result, then RF.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic            ew,
    input logic [4:0]      ed,
    input logic [XLEN-1:0] edata,
    input logic            mw,
    input logic [4:0]      md,
    input logic [XLEN-1:0] mdata
  );
    if (addr == 5'd0)            return '0;
    else if (ew && (ed == addr)) return edata;
    else if (mw && (md == addr)) return mdata;
    else                         return rf_data;
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_func3;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;
  logic [XLEN-1:0] w_op1, w_op2, w_link, w_jalr_sum;
  logic [XLEN-1:0] w_data1, w_data2, w_ls_offset, w_target;
  logic            w_legal, w_rs1_read, w_rs2_read, w_wreg, w_take, w_cond;
  logic            w_hazard, w_accept, w_cnt_inc;

  assign w_opcode   = inst_i[6:0];
  assign w_func3    = inst_i[14:12];
  assign w_rd       = inst_i[11:7];
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  assign w_imm_i = sext32({{20{inst_i[31]}}, inst_i[31:20]});
  assign w_imm_s = sext32({{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]});
  assign w_imm_b = sext32({{19{inst_i[31]}}, inst_i[31], inst_i[7],
                           inst_i[30:25], inst_i[11:8], 1'b0});
  assign w_imm_u = sext32({inst_i[31:12], 12'b0});
  assign w_imm_j = sext32({{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                           inst_i[20], inst_i[30:21], 1'b0});
  assign w_shamt = {{(XLEN-5){1'b0}}, inst_i[24:20]};

  assign w_op1 = pick_operand(rs1_addr_o, rs1_data_i, exe_wreg_i, exe_wd_i,
                              exe_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign w_op2 = pick_operand(rs2_addr_o, rs2_data_i, exe_wreg_i, exe_wd_i,
                              exe_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);

  assign w_link     = pc_i + XLEN'(4);
  assign w_jalr_sum = w_op1 + w_imm_i;

  always_comb begin
    w_cond = 1'b0;
    case (w_func3)
      3'b000:  w_cond = (w_op1 == w_op2);
      3'b001:  w_cond = (w_op1 != w_op2);
      3'b100:  w_cond = ($signed(w_op1) <  $signed(w_op2));
      3'b101:  w_cond = ($signed(w_op1) >= $signed(w_op2));
      3'b110:  w_cond = (w_op1 <  w_op2);
      3'b111:  w_cond = (w_op1 >= w_op2);
      default: w_cond = 1'b0;
    endcase
  end

  // Instruction decode. An all-zero word has opcode 0 and lands in default.
  always_comb begin
    w_legal     = 1'b0;
    w_rs1_read  = 1'b0;
    w_rs2_read  = 1'b0;
    w_wreg      = 1'b0;
    w_take      = 1'b0;
    w_target    = pc_i + w_imm_b;
    w_data1     = w_op1;
    w_data2     = '0;
    w_ls_offset = '0;
    case (w_opcode)
      c_op_lui: begin
        w_legal = 1'b1; w_wreg = 1'b1; w_data1 = w_imm_u;
      end
      c_op_auipc: begin
        w_legal = 1'b1; w_wreg = 1'b1; w_data1 = pc_i + w_imm_u;
      end
      c_op_jal: begin
        w_legal = 1'b1; w_wreg = 1'b1; w_data1 = w_link;
        w_take  = 1'b1; w_target = pc_i + w_imm_j;
      end
      c_op_jalr: begin
        w_legal = 1'b1; w_wreg = 1'b1; w_rs1_read = 1'b1; w_data1 = w_link;
        w_take  = 1'b1; w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
      end
      c_op_branch: begin
        w_legal = 1'b1; w_rs1_read = 1'b1; w_rs2_read = 1'b1;
        w_data2 = w_op2; w_take = w_cond;
      end
      c_op_load: begin
        w_legal = 1'b1; w_wreg = 1'b1; w_rs1_read = 1'b1; w_ls_offset = w_imm_i;
      end
      c_op_store: begin
        w_legal = 1'b1; w_rs1_read = 1'b1; w_rs2_read = 1'b1;
        w_data2 = w_op2; w_ls_offset = w_imm_s;
      end
      c_op_imm: begin
        w_legal = 1'b1; w_wreg = 1'b1; w_rs1_read = 1'b1;
        // Shifts carry only shamt; func7 travels separately to mark SRAI.
        w_data2 = ((w_func3 == 3'b001) || (w_func3 == 3'b101)) ? w_shamt : w_imm_i;
      end
      c_op_op: begin
        w_legal = 1'b1; w_wreg = 1'b1; w_rs1_read = 1'b1; w_rs2_read = 1'b1;
        w_data2 = w_op2;
      end
      default: ;
    endcase
  end

  // Load-use: the EXE load result is not available for forwarding yet.
  assign w_hazard = if_valid_i & exe_wreg_i & exe_is_load_i & (exe_wd_i != 5'd0) &
                    ((w_rs1_read & (rs1_addr_o == exe_wd_i)) |
                     (w_rs2_read & (rs2_addr_o == exe_wd_i)));

  assign id_ready_o = rdy & ~w_hazard & ~ex_stall_i;
  assign w_accept   = if_valid_i & id_ready_o & ~flush_i;
  assign w_cnt_inc  = w_hazard & ~flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o     <= 1'b0;
      pc_o           <= '0;
      opcode_o       <= '0;
      func3_o        <= '0;
      func7_o        <= '0;
      data1_o        <= '0;
      data2_o        <= '0;
      ls_offset_o    <= '0;
      wd_o           <= '0;
      wreg_o         <= 1'b0;
      branch_taken_o <= 1'b0;
      branch_addr_o  <= '0;
      stall_cnt_o    <= '0;
    end else if (rdy) begin
      if (w_cnt_inc && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (flush_i) begin
        ex_valid_o     <= 1'b0;
        branch_taken_o <= 1'b0;
      end else if (ex_stall_i) begin
        branch_taken_o <= 1'b0;
      end else if (w_accept && w_legal) begin
        ex_valid_o     <= 1'b1;
        pc_o           <= pc_i;
        opcode_o       <= w_opcode;
        func3_o        <= w_func3;
        func7_o        <= inst_i[31:25];
        data1_o        <= w_data1;
        data2_o        <= w_data2;
        ls_offset_o    <= w_ls_offset;
        wd_o           <= w_rd;
        wreg_o         <= w_wreg;
        branch_taken_o <= w_take;
        if (w_take) begin
          branch_addr_o <= w_target;
        end
      end else begin
        ex_valid_o     <= 1'b0;
        wreg_o         <= 1'b0;
        branch_taken_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_id_reg
// Purpose  : Self-checking bench for stage_id_reg: directed scenarios plus a
//            randomized run against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_id_reg;

  localparam int XLEN = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst, rdy, if_valid_i;
  logic [31:0]     pc_i, inst_i;
  logic            id_ready_o;
  logic [4:0]      rs1_addr_o, rs2_addr_o;
  logic [31:0]     rs1_data_i, rs2_data_i;
  logic            exe_wreg_i, exe_is_load_i, mem_wreg_i;
  logic [4:0]      exe_wd_i, mem_wd_i;
  logic [31:0]     exe_wdata_i, mem_wdata_i;
  logic            ex_stall_i, flush_i;
  logic            ex_valid_o, wreg_o, branch_taken_o;
  logic [31:0]     pc_o, data1_o, data2_o, ls_offset_o, branch_addr_o;
  logic [6:0]      opcode_o, func7_o;
  logic [2:0]      func3_o;
  logic [4:0]      wd_o;
  logic [CW-1:0]   stall_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stage_id_reg #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_valid_i(if_valid_i), .pc_i(pc_i),
    .inst_i(inst_i), .id_ready_o(id_ready_o), .rs1_addr_o(rs1_addr_o),
    .rs2_addr_o(rs2_addr_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .exe_wreg_i(exe_wreg_i), .exe_wd_i(exe_wd_i), .exe_wdata_i(exe_wdata_i),
    .exe_is_load_i(exe_is_load_i), .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
    .mem_wdata_i(mem_wdata_i), .ex_stall_i(ex_stall_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .pc_o(pc_o), .opcode_o(opcode_o), .func3_o(func3_o),
    .func7_o(func7_o), .data1_o(data1_o), .data2_o(data2_o),
    .ls_offset_o(ls_offset_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .branch_taken_o(branch_taken_o), .branch_addr_o(branch_addr_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // ---------------- reference model ----------------
  typedef enum int {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_IMM, K_OP, K_ILL} kind_t;

  logic        e_valid, e_wreg, e_bt;
  logic [31:0] e_pc, e_d1, e_d2, e_ls, e_ba;
  logic [6:0]  e_opc, e_f7;
  logic [2:0]  e_f3;
  logic [4:0]  e_wd;
  int          e_cnt;

  function automatic kind_t kind_of(input logic [31:0] w);
    case (w[6:0])
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      7'h6F: return K_JAL;
      7'h67: return K_JALR;
      7'h63: return K_BR;
      7'h03: return K_LD;
      7'h23: return K_ST;
      7'h13: return K_IMM;
      7'h33: return K_OP;
      default: return K_ILL;
    endcase
  endfunction

  function automatic bit uses_rs1(input kind_t k);
    return k inside {K_JALR, K_BR, K_LD, K_ST, K_IMM, K_OP};
  endfunction

  function automatic bit uses_rs2(input kind_t k);
    return k inside {K_BR, K_ST, K_OP};
  endfunction

  function automatic logic [31:0] model_op(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (exe_wreg_i && exe_wd_i == a) return exe_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
    return rf;
  endfunction

  function automatic bit model_hazard();
    kind_t k;
    bit    m1, m2;
    k  = kind_of(inst_i);
    m1 = uses_rs1(k) && (inst_i[19:15] == exe_wd_i);
    m2 = uses_rs2(k) && (inst_i[24:20] == exe_wd_i);
    return if_valid_i && exe_wreg_i && exe_is_load_i && (exe_wd_i != 5'd0) && (m1 || m2);
  endfunction

  task automatic model_reset();
    e_valid = 0; e_wreg = 0; e_bt = 0; e_pc = 0; e_d1 = 0; e_d2 = 0; e_ls = 0;
    e_ba = 0; e_opc = 0; e_f7 = 0; e_f3 = 0; e_wd = 0; e_cnt = 0;
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_clock();
    kind_t       k;
    bit          hz, take;
    logic [31:0] a, b, w, imm_i, imm_s, imm_b, imm_u, imm_j, tgt;
    w     = inst_i;
    k     = kind_of(w);
    hz    = model_hazard();
    a     = model_op(w[19:15], rs1_data_i);
    b     = model_op(w[24:20], rs2_data_i);
    imm_i = 32'(w[31:20]) - (w[31] ? 32'd4096 : 32'd0);
    imm_s = 32'({w[31:25], w[11:7]}) - (w[31] ? 32'd4096 : 32'd0);
    imm_b = 32'({w[31], w[7], w[30:25], w[11:8], 1'b0}) - (w[31] ? 32'd8192 : 32'd0);
    imm_j = 32'({w[31], w[19:12], w[20], w[30:21], 1'b0}) - (w[31] ? 32'h0020_0000 : 32'd0);
    imm_u = w & 32'hFFFF_F000;
    take  = 0;
    tgt   = 0;
    if (!rdy) return;
    if (hz && !flush_i && e_cnt < CMAX) e_cnt = e_cnt + 1;
    if (flush_i) begin
      e_valid = 0; e_bt = 0;
    end else if (ex_stall_i) begin
      e_bt = 0;
    end else if (if_valid_i && !hz && k != K_ILL) begin
      e_valid = 1; e_pc = pc_i; e_opc = w[6:0]; e_f3 = w[14:12]; e_f7 = w[31:25];
      e_wd    = w[11:7];
      e_wreg  = k inside {K_LUI, K_AUIPC, K_JAL, K_JALR, K_LD, K_IMM, K_OP};
      case (k)
        K_LUI:        e_d1 = imm_u;
        K_AUIPC:      e_d1 = pc_i + imm_u;
        K_JAL, K_JALR: e_d1 = pc_i + 32'd4;
        default:      e_d1 = a;
      endcase
      case (k)
        K_IMM:             e_d2 = (w[14:12] == 3'd1 || w[14:12] == 3'd5) ? 32'(w[24:20]) : imm_i;
        K_OP, K_BR, K_ST:  e_d2 = b;
        default:           e_d2 = 0;
      endcase
      e_ls = (k == K_LD) ? imm_i : (k == K_ST) ? imm_s : 32'd0;
      case (k)
        K_JAL:  begin take = 1; tgt = pc_i + imm_j; end
        K_JALR: begin take = 1; tgt = a + imm_i; tgt[0] = 1'b0; end
        K_BR: begin
          tgt = pc_i + imm_b;
          case (w[14:12])
            3'd0: take = (a == b);
            3'd1: take = (a != b);
            3'd4: take = ($signed(a) <  $signed(b));
            3'd5: take = ($signed(a) >= $signed(b));
            3'd6: take = (a <  b);
            3'd7: take = (a >= b);
            default: take = 0;
          endcase
        end
        default: take = 0;
      endcase
      e_bt = take;
      if (take) e_ba = tgt;
    end else begin
      e_valid = 0; e_wreg = 0; e_bt = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_defaults();
    rdy = 1; if_valid_i = 0; pc_i = 0; inst_i = 0; rs1_data_i = 0; rs2_data_i = 0;
    exe_wreg_i = 0; exe_wd_i = 0; exe_wdata_i = 0; exe_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0; ex_stall_i = 0; flush_i = 0;
  endtask

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  opc;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 10);
    case (k)
      0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;
      4: opc = 7'h63;  5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;
      8: opc = 7'h33;  9: opc = 7'($urandom);
      default: return 32'h0;
    endcase
    w[6:0]   = opc;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  localparam logic [31:0] c_add_x6_x5 = {7'd0, 5'd0, 5'd5, 3'd0, 5'd6, 7'b0110011};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_defaults();
    rst = 1; if_valid_i = 1; inst_i = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ex_valid_o); end
    total++; if (data1_o !== 32'd0 || data2_o !== 32'd0 || pc_o !== 32'd0 || branch_addr_o !== 32'd0)
      begin bad++; $display("FAIL reset_data got d1=%h d2=%h pc=%h ba=%h exp=0", data1_o, data2_o, pc_o, branch_addr_o); end
    total++; if (branch_taken_o !== 1'b0 || stall_cnt_o !== '0)
      begin bad++; $display("FAIL reset_ctrl got bt=%b cnt=%0d exp=0", branch_taken_o, stall_cnt_o); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    total++; if (ex_valid_o !== 1'b0 || wreg_o !== 1'b0 || stall_cnt_o !== '0)
      begin bad++; $display("FAIL zero_inst got v=%b wreg=%b cnt=%0d exp=0/0/0", ex_valid_o, wreg_o, stall_cnt_o); end
  endtask

  task automatic test_addi();
    @(negedge clk); drive_defaults();
    if_valid_i = 1; pc_i = 32'h100; inst_i = 32'h0050_0093;
    @(posedge clk); #1;
    total++; if (ex_valid_o !== 1'b1 || wreg_o !== 1'b1 || wd_o !== 5'd1)
      begin bad++; $display("FAIL addi_ctrl got v=%b wreg=%b wd=%0d exp=1/1/1", ex_valid_o, wreg_o, wd_o); end
    total++; if (data1_o !== 32'd0 || data2_o !== 32'd5)
      begin bad++; $display("FAIL addi_data got d1=%h d2=%h exp=0/5", data1_o, data2_o); end
    total++; if (pc_o !== 32'h100 || opcode_o !== 7'h13)
      begin bad++; $display("FAIL addi_pc got pc=%h opc=%h exp=100/13", pc_o, opcode_o); end
  endtask

  task automatic test_forward();
    @(negedge clk); drive_defaults();
    if_valid_i = 1; inst_i = 32'h0020_81B3; rs1_data_i = 32'hAAAA; rs2_data_i = 32'hBBBB;
    exe_wreg_i = 1; exe_wd_i = 1; exe_wdata_i = 7; mem_wreg_i = 1; mem_wd_i = 2; mem_wdata_i = 9;
    @(posedge clk); #1;
    total++; if (data1_o !== 32'd7 || data2_o !== 32'd9 || wd_o !== 5'd3)
      begin bad++; $display("FAIL fwd_exe_mem got d1=%h d2=%h wd=%0d exp=7/9/3", data1_o, data2_o, wd_o); end
    @(negedge clk); exe_wd_i = 2; mem_wd_i = 2;
    @(posedge clk); #1;
    total++; if (data1_o !== 32'hAAAA || data2_o !== 32'd7)
      begin bad++; $display("FAIL fwd_priority got d1=%h d2=%h exp=aaaa/7", data1_o, data2_o); end
  endtask

  task automatic test_load_use();
    @(negedge clk); drive_defaults();
    if_valid_i = 1; inst_i = c_add_x6_x5;
    exe_wreg_i = 1; exe_wd_i = 5; exe_is_load_i = 1; exe_wdata_i = 32'hDEAD;
    #1;
    total++; if (id_ready_o !== 1'b0) begin bad++; $display("FAIL lu_ready got=%b exp=0", id_ready_o); end
    @(posedge clk); #1;
    total++; if (ex_valid_o !== 1'b0 || stall_cnt_o !== 4'd1)
      begin bad++; $display("FAIL lu_bubble got v=%b cnt=%0d exp=0/1", ex_valid_o, stall_cnt_o); end
    @(negedge clk);
    exe_wreg_i = 0; exe_is_load_i = 0; mem_wreg_i = 1; mem_wd_i = 5; mem_wdata_i = 32'h55;
    #1;
    total++; if (id_ready_o !== 1'b1) begin bad++; $display("FAIL lu_ready2 got=%b exp=1", id_ready_o); end
    @(posedge clk); #1;
    total++; if (ex_valid_o !== 1'b1 || data1_o !== 32'h55 || wd_o !== 5'd6 || stall_cnt_o !== 4'd1)
      begin bad++; $display("FAIL lu_accept got v=%b d1=%h wd=%0d cnt=%0d exp=1/55/6/1", ex_valid_o, data1_o, wd_o, stall_cnt_o); end
  endtask

  task automatic test_branch();
    @(negedge clk); drive_defaults();
    if_valid_i = 1; pc_i = 32'h200; inst_i = enc_b(13'd16, 5'd2, 5'd1, 3'b100);
    rs1_data_i = 32'hFFFF_FFFF; rs2_data_i = 32'd1;
    @(posedge clk); #1;
    total++; if (branch_taken_o !== 1'b1 || branch_addr_o !== 32'h210)
      begin bad++; $display("FAIL blt_taken got bt=%b ba=%h exp=1/210", branch_taken_o, branch_addr_o); end
    total++; if (wreg_o !== 1'b0 || data2_o !== 32'd1)
      begin bad++; $display("FAIL blt_fields got wreg=%b d2=%h exp=0/1", wreg_o, data2_o); end
    @(negedge clk); inst_i = enc_b(13'd16, 5'd2, 5'd1, 3'b110);
    @(posedge clk); #1;
    total++; if (branch_taken_o !== 1'b0 || branch_addr_o !== 32'h210 || ex_valid_o !== 1'b1)
      begin bad++; $display("FAIL bltu_not got bt=%b ba=%h v=%b exp=0/210/1", branch_taken_o, branch_addr_o, ex_valid_o); end
  endtask

  task automatic test_jalr_flush();
    @(negedge clk); drive_defaults();
    if_valid_i = 1; pc_i = 32'h40; inst_i = {12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111};
    rs1_data_i = 32'h305;
    @(posedge clk); #1;
    total++; if (branch_taken_o !== 1'b1 || branch_addr_o !== 32'h304 || data1_o !== 32'h44)
      begin bad++; $display("FAIL jalr got bt=%b ba=%h d1=%h exp=1/304/44", branch_taken_o, branch_addr_o, data1_o); end
    @(negedge clk); flush_i = 1;
    @(posedge clk); #1;
    total++; if (ex_valid_o !== 1'b0 || branch_taken_o !== 1'b0 || branch_addr_o !== 32'h304)
      begin bad++; $display("FAIL jalr_flush got v=%b bt=%b ba=%h exp=0/0/304", ex_valid_o, branch_taken_o, branch_addr_o); end
  endtask

  task automatic test_stall_count();
    @(negedge clk); drive_defaults();
    if_valid_i = 1; inst_i = c_add_x6_x5; exe_wreg_i = 1; exe_wd_i = 5; exe_is_load_i = 1;
    flush_i = 1;
    @(posedge clk); #1;
    total++; if (stall_cnt_o !== 4'd1 || ex_valid_o !== 1'b0)
      begin bad++; $display("FAIL flush_hazard got cnt=%0d v=%b exp=1/0", stall_cnt_o, ex_valid_o); end
    @(negedge clk); flush_i = 0; rdy = 0;
    repeat (3) @(posedge clk); #1;
    total++; if (stall_cnt_o !== 4'd1) begin bad++; $display("FAIL rdy_freeze got cnt=%0d exp=1", stall_cnt_o); end
    @(negedge clk); rdy = 1;
    repeat (20) @(posedge clk); #1;
    total++; if (stall_cnt_o !== 4'(CMAX)) begin bad++; $display("FAIL saturate got cnt=%0d exp=%0d", stall_cnt_o, CMAX); end
    @(negedge clk); #2 rst = 1; #1;
    total++; if (stall_cnt_o !== '0 || ex_valid_o !== 1'b0)
      begin bad++; $display("FAIL async_rst_stall got cnt=%0d v=%b exp=0/0", stall_cnt_o, ex_valid_o); end
    @(negedge clk); rst = 0; drive_defaults();
    if_valid_i = 1; pc_i = 32'h80; inst_i = 32'h0080_006F;
    @(posedge clk); #1;
    total++; if (branch_taken_o !== 1'b1 || branch_addr_o !== 32'h88)
      begin bad++; $display("FAIL jal got bt=%b ba=%h exp=1/88", branch_taken_o, branch_addr_o); end
    #2 rst = 1; #1;
    total++; if (branch_taken_o !== 1'b0 || branch_addr_o !== 32'd0)
      begin bad++; $display("FAIL async_rst_pulse got bt=%b ba=%h exp=0/0", branch_taken_o, branch_addr_o); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_random();
    logic exp_rdy;
    @(negedge clk); drive_defaults(); rst = 1;
    @(negedge clk); rst = 0;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rdy           = ($urandom_range(0, 9) != 0);
      if_valid_i    = ($urandom_range(0, 9) != 0);
      flush_i       = ($urandom_range(0, 11) == 0);
      ex_stall_i    = ($urandom_range(0, 7) == 0);
      pc_i          = $urandom & 32'hFFFF_FFFC;
      inst_i        = rand_inst();
      rs1_data_i    = $urandom;
      rs2_data_i    = ($urandom_range(0, 1) == 1) ? rs1_data_i : $urandom;
      exe_wreg_i    = ($urandom_range(0, 4) < 3);
      exe_wd_i      = 5'($urandom_range(0, 3));
      exe_wdata_i   = $urandom;
      exe_is_load_i = ($urandom_range(0, 4) < 2);
      mem_wreg_i    = ($urandom_range(0, 4) < 3);
      mem_wd_i      = 5'($urandom_range(0, 3));
      mem_wdata_i   = $urandom;
      #1;
      exp_rdy = rdy && !model_hazard() && !ex_stall_i;
      total++; if (id_ready_o !== exp_rdy) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, id_ready_o, exp_rdy); end
      total++; if (rs1_addr_o !== inst_i[19:15] || rs2_addr_o !== inst_i[24:20])
        begin bad++; $display("FAIL rnd_raddr n=%0d got=%0d/%0d exp=%0d/%0d", n, rs1_addr_o, rs2_addr_o, inst_i[19:15], inst_i[24:20]); end
      model_clock();
      @(posedge clk); #1;
      total++; if (ex_valid_o !== e_valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, ex_valid_o, e_valid); end
      total++; if (pc_o !== e_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc_o, e_pc); end
      total++; if (opcode_o !== e_opc || func3_o !== e_f3 || func7_o !== e_f7)
        begin bad++; $display("FAIL rnd_fields n=%0d got=%h/%h/%h exp=%h/%h/%h", n, opcode_o, func3_o, func7_o, e_opc, e_f3, e_f7); end
      total++; if (data1_o !== e_d1) begin bad++; $display("FAIL rnd_data1 n=%0d got=%h exp=%h", n, data1_o, e_d1); end
      total++; if (data2_o !== e_d2) begin bad++; $display("FAIL rnd_data2 n=%0d got=%h exp=%h", n, data2_o, e_d2); end
      total++; if (ls_offset_o !== e_ls) begin bad++; $display("FAIL rnd_ls n=%0d got=%h exp=%h", n, ls_offset_o, e_ls); end
      total++; if (wd_o !== e_wd || wreg_o !== e_wreg)
        begin bad++; $display("FAIL rnd_wb n=%0d got=%0d/%b exp=%0d/%b", n, wd_o, wreg_o, e_wd, e_wreg); end
      total++; if (branch_taken_o !== e_bt) begin bad++; $display("FAIL rnd_bt n=%0d got=%b exp=%b", n, branch_taken_o, e_bt); end
      total++; if (branch_addr_o !== e_ba) begin bad++; $display("FAIL rnd_ba n=%0d got=%h exp=%h", n, branch_addr_o, e_ba); end
      total++; if (stall_cnt_o !== CW'(e_cnt)) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, stall_cnt_o, e_cnt); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_addi();
    test_forward();
    test_load_use();
    test_branch();
    test_jalr_flush();
    test_stall_count();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
